game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 179 +++++++++++++++++
 tb/tb_game_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Purpose : jump-game controller; charge-and-release jump, landing check, block scroll, score.
// Latency : every output is a register; key edges and frame ticks take effect on the next clk edge.
// Backpressure: none; i_frame_tick paces motion, i_key edges advance the game state.
// Ports   : clk, rst_n (async active-low); i_key (debounced level), i_frame_tick (1-clk pulse/frame);
//           o_x/en/type_block1|2 (current/next block), o_x_man/o_y_man/o_squeeze_man (man sprite),
//           o_title/o_gameover (overlays), o_score (landed jumps, saturating).
module game_ctrl #(
  parameter int BLOCK_W     = 48,
  parameter int HOME_X      = 64,
  parameter int MAN_X0      = 80,
  parameter int SCROLL_STEP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key,
  input  logic       i_frame_tick,
  output logic [9:0] o_x_block1,
  output logic [9:0] o_x_block2,
  output logic       o_en_block1,
  output logic       o_en_block2,
  output logic [3:0] o_type_block1,
  output logic [3:0] o_type_block2,
  output logic [9:0] o_x_man,
  output logic [9:0] o_y_man,
  output logic [3:0] o_squeeze_man,
  output logic       o_title,
  output logic       o_gameover,
  output logic [7:0] o_score
);

  typedef enum logic [2:0] {TITLE, IDLE, CHARGE, JUMP, CHECK, SCROLL, OVER} state_t;

  localparam logic [9:0]  HOME    = 10'(HOME_X);
  localparam logic [9:0]  MAN0    = 10'(MAN_X0);
  localparam logic [9:0]  STEP_MX = 10'(SCROLL_STEP);
  localparam logic [9:0]  X2_INIT = 10'd224;
  localparam logic [10:0] BW_M1   = 11'(BLOCK_W - 1);
  localparam logic [15:0] SEED    = 16'hACE1;

  state_t      state;
  logic        key_q;
  logic [15:0] lfsr;
  logic [5:0]  charge;
  logic [3:0]  step;
  logic [4:0]  t;

  logic        key_rise, key_fall;
  logic        lfsr_fb;
  logic [5:0]  charge_inc;
  logic [4:0]  t_next;
  logic [9:0]  t10, y_next;
  logic        in_blk1, in_blk2;
  logic [9:0]  gap, d;

  always_comb begin
    key_rise   = i_key & ~key_q;
    key_fall   = ~i_key & key_q;
    // taps 16,14,13,11 in 1-based numbering
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    charge_inc = charge + 6'd1;
    t_next     = t + 5'd1;
    t10        = {5'b0, t_next};
    // parabola t*(16-t): 0 at t=0 and t=16, 64 at t=8
    y_next     = t10 * (10'd16 - t10);
    in_blk2    = ({1'b0, o_x_man} >= {1'b0, o_x_block2}) &&
                 ({1'b0, o_x_man} <= {1'b0, o_x_block2} + BW_M1);
    in_blk1    = ({1'b0, o_x_man} >= {1'b0, o_x_block1}) &&
                 ({1'b0, o_x_man} <= {1'b0, o_x_block1} + BW_M1);
    gap        = o_x_block2 - HOME;
    d          = (gap > STEP_MX) ? STEP_MX : gap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= TITLE;
      key_q         <= 1'b0;
      lfsr          <= SEED;
      charge        <= '0;
      step          <= '0;
      t             <= '0;
      o_x_block1    <= HOME;
      o_x_block2    <= X2_INIT;
      o_en_block1   <= 1'b1;
      o_en_block2   <= 1'b1;
      o_type_block1 <= '0;
      o_type_block2 <= '0;
      o_x_man       <= MAN0;
      o_y_man       <= '0;
      o_squeeze_man <= '0;
      o_title       <= 1'b1;
      o_gameover    <= 1'b0;
      o_score       <= '0;
    end else begin
      // edge detector and LFSR keep running in every state, including the restart
      key_q <= i_key;
      lfsr  <= {lfsr[14:0], lfsr_fb};
      case (state)
        TITLE: if (key_rise) begin
          state   <= IDLE;
          o_title <= 1'b0;
        end
        IDLE: if (key_rise) begin
          charge <= '0;
          state  <= CHARGE;
        end
        CHARGE: begin
          // a release landing on a tick wins: the tick is not counted
          if (key_fall) begin
            step          <= charge[5:2];
            t             <= '0;
            o_squeeze_man <= '0;
            state         <= JUMP;
          end else if (i_frame_tick && charge != 6'd63) begin
            charge        <= charge_inc;
            o_squeeze_man <= charge_inc[5:2];
          end
        end
        JUMP: if (i_frame_tick) begin
          t       <= t_next;
          o_x_man <= o_x_man + {6'b0, step};
          o_y_man <= y_next;
          if (t_next == 5'd16) state <= CHECK;
        end
        CHECK: begin
          if (in_blk2) begin
            if (o_score != 8'hFF) o_score <= o_score + 8'd1;
            state <= SCROLL;
          end else if (in_blk1) begin
            state <= IDLE;
          end else begin
            o_gameover <= 1'b1;
            state      <= OVER;
          end
        end
        SCROLL: begin
          if (o_x_block2 == HOME) begin
            // next block becomes current; draw a fresh next block 96..159 px ahead
            o_x_block1    <= o_x_block2;
            o_type_block1 <= o_type_block2;
            o_en_block1   <= 1'b1;
            o_x_block2    <= HOME + 10'd96 + {4'b0, lfsr[5:0]};
            o_type_block2 <= lfsr[9:6];
            state         <= IDLE;
          end else if (i_frame_tick) begin
            o_x_man    <= o_x_man - d;
            o_x_block2 <= o_x_block2 - d;
            // old block slides off the left edge; clamp instead of wrapping
            if (o_x_block1 > d) begin
              o_x_block1 <= o_x_block1 - d;
            end else begin
              o_x_block1  <= '0;
              o_en_block1 <= 1'b0;
            end
          end
        end
        OVER: if (key_rise) begin
          state         <= TITLE;
          charge        <= '0;
          step          <= '0;
          t             <= '0;
          o_x_block1    <= HOME;
          o_x_block2    <= X2_INIT;
          o_en_block1   <= 1'b1;
          o_en_block2   <= 1'b1;
          o_type_block1 <= '0;
          o_type_block2 <= '0;
          o_x_man       <= MAN0;
          o_y_man       <= '0;
          o_squeeze_man <= '0;
          o_title       <= 1'b1;
          o_gameover    <= 1'b0;
          o_score       <= '0;
        end
        default: state <= TITLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Purpose : self-checking bench for game_ctrl (jump outcomes, scroll, restart, async reset).
// Latency : inputs driven on negedge, outputs sampled on negedge, one clk after the driving edge.
// Backpressure: none; bench paces ticks and key edges directly.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_key = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic [9:0] o_x_block1, o_x_block2, o_x_man, o_y_man;
  logic       o_en_block1, o_en_block2, o_title, o_gameover;
  logic [3:0] o_type_block1, o_type_block2, o_squeeze_man;
  logic [7:0] o_score;

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_key(i_key), .i_frame_tick(i_frame_tick),
    .o_x_block1(o_x_block1), .o_x_block2(o_x_block2),
    .o_en_block1(o_en_block1), .o_en_block2(o_en_block2),
    .o_type_block1(o_type_block1), .o_type_block2(o_type_block2),
    .o_x_man(o_x_man), .o_y_man(o_y_man), .o_squeeze_man(o_squeeze_man),
    .o_title(o_title), .o_gameover(o_gameover), .o_score(o_score)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int ticks;      // frame ticks while charging
    bit fall_tick;  // release coincides with one extra tick
    int sq;         // expected squeeze before release
    int x;          // expected x_man after landing check
    int score;
    bit over;
  } vec_t;

  typedef struct {
    int x;
    int score;
    bit over;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  exp_t e;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    i_key = 1'b0;
    i_frame_tick = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic press();
    @(negedge clk) i_key = 1'b1;
    cyc(1);
  endtask

  task automatic release_key();
    @(negedge clk) i_key = 1'b0;
    cyc(1);
  endtask

  task automatic tick();
    @(negedge clk) i_frame_tick = 1'b1;
    @(negedge clk) i_frame_tick = 1'b0;
  endtask

  // TITLE -> IDLE -> CHARGE
  task automatic start_charge();
    press();
    release_key();
    press();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " title"},    int'(o_title), 1);
    chk({tag, " gameover"}, int'(o_gameover), 0);
    chk({tag, " x_man"},    int'(o_x_man), 80);
    chk({tag, " y_man"},    int'(o_y_man), 0);
    chk({tag, " squeeze"},  int'(o_squeeze_man), 0);
    chk({tag, " score"},    int'(o_score), 0);
    chk({tag, " x_block1"}, int'(o_x_block1), 64);
    chk({tag, " x_block2"}, int'(o_x_block2), 224);
    chk({tag, " en1"},      int'(o_en_block1), 1);
    chk({tag, " en2"},      int'(o_en_block2), 1);
    chk({tag, " type1"},    int'(o_type_block1), 0);
    chk({tag, " type2"},    int'(o_type_block2), 0);
  endtask

  initial begin
    // landing x = 80 + 16*step; block1 spans 64..111, block2 spans 224..271
    vecs[0] = '{ticks: 3,   fall_tick: 0, sq: 0,  x: 80,  score: 0, over: 0};
    vecs[1] = '{ticks: 24,  fall_tick: 0, sq: 6,  x: 176, score: 0, over: 1};
    vecs[2] = '{ticks: 100, fall_tick: 0, sq: 15, x: 320, score: 0, over: 1};
    vecs[3] = '{ticks: 7,   fall_tick: 1, sq: 1,  x: 96,  score: 0, over: 0};
    vecs[4] = '{ticks: 8,   fall_tick: 0, sq: 2,  x: 112, score: 0, over: 1};
    vecs[5] = '{ticks: 36,  fall_tick: 0, sq: 9,  x: 224, score: 1, over: 0};
    vecs[6] = '{ticks: 4,   fall_tick: 0, sq: 1,  x: 96,  score: 0, over: 0};
    vecs[7] = '{ticks: 48,  fall_tick: 0, sq: 12, x: 272, score: 0, over: 1};

    // reset state
    cyc(2);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cyc(2);

    // full jump onto block2 and scroll
    start_charge();
    chk("title after key", int'(o_title), 0);
    repeat (40) tick();
    chk("squeeze 40", int'(o_squeeze_man), 10);
    release_key();
    chk("squeeze at release", int'(o_squeeze_man), 0);
    repeat (5) tick();
    chk("y t5", int'(o_y_man), 55);
    repeat (3) tick();
    chk("y peak t8", int'(o_y_man), 64);
    chk("x t8", int'(o_x_man), 160);
    repeat (8) tick();
    cyc(3);
    chk("x landed", int'(o_x_man), 240);
    chk("score 1", int'(o_score), 1);
    chk("y landed", int'(o_y_man), 0);
    repeat (8) tick();
    chk("scroll x_block1 clamp", int'(o_x_block1), 0);
    chk("scroll en1 drop", int'(o_en_block1), 0);
    chk("scroll x_block2", int'(o_x_block2), 160);
    chk("scroll x_man", int'(o_x_man), 176);
    tick();
    chk("scroll x_block1 stays 0", int'(o_x_block1), 0);
    repeat (11) tick();
    cyc(3);
    chk("after scroll x_man", int'(o_x_man), 80);
    chk("after scroll x_block1", int'(o_x_block1), 64);
    chk("after scroll en1", int'(o_en_block1), 1);
    chk("after scroll type1", int'(o_type_block1), 0);
    chk_rng("new x_block2", int'(o_x_block2), 160, 223);
    chk("after scroll score", int'(o_score), 1);

    // table-driven jump outcomes, each from a fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      start_charge();
      repeat (vecs[i].ticks) tick();
      chk($sformatf("v%0d squeeze", i), int'(o_squeeze_man), vecs[i].sq);
      sb.push_back('{x: vecs[i].x, score: vecs[i].score, over: vecs[i].over});
      if (vecs[i].fall_tick) begin
        @(negedge clk);
        i_key = 1'b0;
        i_frame_tick = 1'b1;
        @(negedge clk) i_frame_tick = 1'b0;
      end else begin
        release_key();
      end
      chk($sformatf("v%0d squeeze rel", i), int'(o_squeeze_man), 0);
      repeat (16) tick();
      cyc(3);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL v%0d scoreboard empty: got 0 entries, expected 1", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d x_man", i), int'(o_x_man), e.x);
        chk($sformatf("v%0d score", i), int'(o_score), e.score);
        chk($sformatf("v%0d gameover", i), int'(o_gameover), int'(e.over));
        chk($sformatf("v%0d y_man", i), int'(o_y_man), 0);
      end
    end

    // last vector ended in OVER: key rise restarts to TITLE with reset values
    press();
    chk_reset_vals("restart");
    release_key();

    // asynchronous reset in the middle of a jump (t=5)
    do_reset();
    start_charge();
    repeat (20) tick();
    release_key();
    repeat (5) tick();
    chk("pre-rst y t5", int'(o_y_man), 55);
    chk("pre-rst x t5", int'(o_x_man), 105);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
